// File: rtl/zeroriscy_alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Holds the operator encoding, the controller state encoding, and a helper
// that classifies an operator as a shift or rotate.
package zeroriscy_defines;

  localparam int ALU_MC_OP_WIDTH = 4;

  typedef enum logic [ALU_MC_OP_WIDTH-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR,
    ALU_SLT, ALU_SLTU, ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU
  } alu_mc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_mc_state_e;

  function automatic logic is_shift_op(input alu_mc_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA) ||
           (op == ALU_ROL) || (op == ALU_ROR);
  endfunction

endpackage

// File: rtl/zeroriscy_alu_mc_shstep.sv
// Combinational single-step shifter used by the iterative shift datapath.
// Ports:
//   i_data    data to shift
//   i_amt     shift amount for this step, 0..SHIFT_STEP
//   i_left    1 = shift/rotate left, 0 = right
//   i_arith   right shift fills with the sign bit (ignored when i_left=1)
//   i_rotate  bits shifted out re-enter at the other end
//   o_data    shifted result
module zeroriscy_alu_mc_shstep #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4,
  parameter int AW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  input  logic             i_left,
  input  logic             i_arith,
  input  logic             i_rotate,
  output logic [WIDTH-1:0] o_data
);

  // Wide enough to hold WIDTH itself, needed for the wrap-around complement.
  localparam int SW = $clog2(WIDTH) + 1;

  logic [SW-1:0]    w_amt;
  logic [SW-1:0]    w_comp;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_wrap_l;
  logic [WIDTH-1:0] w_wrap_r;

  assign w_amt  = SW'(i_amt);
  // For amt==0 the complement is WIDTH, and shifting by WIDTH yields 0,
  // so rotate-by-zero naturally returns the input.
  assign w_comp = SW'(WIDTH) - w_amt;

  assign w_shl    = i_data << w_amt;
  assign w_shr    = i_data >> w_amt;
  assign w_sra    = $signed(i_data) >>> w_amt;
  assign w_wrap_l = i_data >> w_comp;
  assign w_wrap_r = i_data << w_comp;

  always_comb begin
    o_data = w_shr;
    if (i_left) begin
      o_data = w_shl | (i_rotate ? w_wrap_l : '0);
    end else if (i_arith) begin
      o_data = w_sra;
    end else begin
      o_data = w_shr | (i_rotate ? w_wrap_r : '0);
    end
  end

endmodule

// File: rtl/zeroriscy_alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result.
// Logic/arith/compare/min-max ops complete in one cycle; shifts and rotates
// iterate through a SHIFT_STEP-bit-per-cycle shifter.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush_i               abort in-flight op and drop pending result
//   valid_i / ready_o     request handshake
//   operator_i            alu_mc_op_e encoding
//   operand_a_i/_b_i      operands (shift amount = operand_b_i[SHW-1:0])
//   valid_o / ready_i     result handshake
//   result_o, cmp_result_o registered result and compare flag
//   busy_o                controller not idle
module zeroriscy_alu_mc
  import zeroriscy_defines::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [ALU_MC_OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]           operand_a_i,
  input  logic [WIDTH-1:0]           operand_b_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           result_o,
  output logic                       cmp_result_o,
  output logic                       busy_o
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int SHW1 = SHW + 1;
  localparam int AW   = $clog2(SHIFT_STEP + 1);
  // Remaining-amount arithmetic is one bit wider so SHIFT_STEP==WIDTH fits.
  localparam logic [SHW:0] STEP_L = SHW1'(SHIFT_STEP);

  alu_mc_state_e    r_state;
  alu_mc_op_e       r_op;
  logic [WIDTH-1:0] r_work;
  logic [SHW:0]     r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_cmp;
  logic             r_valid;

  alu_mc_op_e       w_op;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;
  logic             w_start_shift;
  logic             w_lt_s;
  logic             w_lt_u;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_cmp;
  logic [SHW:0]     w_step;
  logic [SHW:0]     w_rem_next;
  logic [WIDTH-1:0] w_sh_out;

  assign w_op     = alu_mc_op_e'(operator_i);
  assign w_shamt  = operand_b_i[SHW-1:0];
  assign ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
  // Flush wins: nothing is accepted in a flush cycle even if ready_o is high.
  assign w_accept = valid_i && ready_o && !flush_i;
  assign w_start_shift = is_shift_op(w_op) && (w_shamt != '0);

  assign w_lt_s = $signed(operand_a_i) < $signed(operand_b_i);
  assign w_lt_u = operand_a_i < operand_b_i;

  // Single-cycle datapath. Shift ops only land here with a zero amount,
  // in which case every shift/rotate returns A unchanged.
  always_comb begin
    w_alu_res = '0;
    w_alu_cmp = 1'b0;
    case (w_op)
      ALU_ADD:  w_alu_res = operand_a_i + operand_b_i;
      ALU_SUB:  w_alu_res = operand_a_i - operand_b_i;
      ALU_AND:  w_alu_res = operand_a_i & operand_b_i;
      ALU_OR:   w_alu_res = operand_a_i | operand_b_i;
      ALU_XOR:  w_alu_res = operand_a_i ^ operand_b_i;
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR:
                w_alu_res = operand_a_i;
      ALU_SLT:  begin w_alu_res = WIDTH'(w_lt_s); w_alu_cmp = w_lt_s; end
      ALU_SLTU: begin w_alu_res = WIDTH'(w_lt_u); w_alu_cmp = w_lt_u; end
      ALU_MIN:  begin w_alu_res = w_lt_s ? operand_a_i : operand_b_i; w_alu_cmp = w_lt_s; end
      ALU_MAX:  begin w_alu_res = w_lt_s ? operand_b_i : operand_a_i; w_alu_cmp = w_lt_s; end
      ALU_MINU: begin w_alu_res = w_lt_u ? operand_a_i : operand_b_i; w_alu_cmp = w_lt_u; end
      ALU_MAXU: begin w_alu_res = w_lt_u ? operand_b_i : operand_a_i; w_alu_cmp = w_lt_u; end
      default:  begin w_alu_res = '0; w_alu_cmp = 1'b0; end
    endcase
  end

  // Each SHIFT cycle moves min(remaining, SHIFT_STEP) bits.
  assign w_step     = (r_rem > STEP_L) ? STEP_L : r_rem;
  assign w_rem_next = r_rem - w_step;

  zeroriscy_alu_mc_shstep #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .AW         (AW)
  ) u_shstep (
    .i_data   (r_work),
    .i_amt    (w_step[AW-1:0]),
    .i_left   ((r_op == ALU_SLL) || (r_op == ALU_ROL)),
    .i_arith  (r_op == ALU_SRA),
    .i_rotate ((r_op == ALU_ROL) || (r_op == ALU_ROR)),
    .o_data   (w_sh_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= ALU_ADD;
      r_work   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_cmp    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (flush_i) begin
      // Result register deliberately left untouched.
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_op    <= w_op;
              r_work  <= operand_a_i;
              r_rem   <= {1'b0, w_shamt};
              r_valid <= 1'b0;
              r_state <= ST_SHIFT;
            end else begin
              r_result <= w_alu_res;
              r_cmp    <= w_alu_cmp;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && ready_i) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_sh_out;
          r_rem  <= w_rem_next;
          if (r_rem <= STEP_L) begin
            r_result <= w_sh_out;
            r_cmp    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o      = r_valid;
  assign result_o     = r_result;
  assign cmp_result_o = r_cmp;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_zeroriscy_alu_mc.sv
// Directed testbench for zeroriscy_alu_mc (WIDTH=32, SHIFT_STEP=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_zeroriscy_alu_mc;
  import zeroriscy_defines::*;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  operator_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        cmp_result_o;
  logic        busy_o;

  int nvec = 0;
  int nerr = 0;

  zeroriscy_alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operator_i   (operator_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .cmp_result_o (cmp_result_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE with ready_i=1, wait (bounded) for the result,
  // check latency/result/flag, then let the result be consumed.
  task automatic run_op(input string tag, input alu_mc_op_e op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_cmp,
                        input int exp_lat);
    int lat;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    valid_i     = 1'b1;
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i     = 1'b0;
    // Scramble inputs: the DUT must have captured them at accept.
    operand_a_i = 32'hDEAD_BEEF;
    operand_b_i = 32'h0000_0003;
    operator_i  = 4'(ALU_XOR);
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("op %-8s a=%h b=%h -> result=%h cmp=%0d latency=%0d",
             tag, a, b, result_o, cmp_result_o, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_cmp"}, 32'(cmp_result_o), 32'(exp_cmp));
    @(negedge clk);
  endtask

  initial begin
    bit seen_valid;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b1;
    operator_i  = 4'(ALU_ADD);
    operand_a_i = '0;
    operand_b_i = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_cmp", 32'(cmp_result_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops
    run_op("ADD", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    run_op("SUB", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("AND", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    run_op("OR",  ALU_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);

    // Shifts and rotates
    run_op("SRA31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 9);
    run_op("SLL5",  ALU_SLL, 32'h0000_0001, 32'd5,  32'h0000_0020, 1'b0, 3);
    run_op("SRL0",  ALU_SRL, 32'h1234_5678, 32'h0000_0100, 32'h1234_5678, 1'b0, 1);
    run_op("ROR1",  ALU_ROR, 32'h0000_0001, 32'h0000_0021, 32'h8000_0000, 1'b0, 2);
    run_op("ROL4",  ALU_ROL, 32'h8000_0001, 32'd4,  32'h0000_0018, 1'b0, 2);
    run_op("SRA4",  ALU_SRA, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 2);

    // Compares and min/max with A=-1, B=1
    run_op("SLTU", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1);
    run_op("MIN",  ALU_MIN,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("MAX",  ALU_MAX,  32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b1, 1);
    run_op("MINU", ALU_MINU, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b0, 1);
    run_op("MAXU", ALU_MAXU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("SLT",  ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b1, 1);

    // Back-to-back throughput
    operator_i = 4'(ALU_ADD); operand_a_i = 32'd5; operand_b_i = 32'd7; valid_i = 1'b1;
    @(negedge clk);
    chk("b2b_valid0", 32'(valid_o), 32'd1);
    chk("b2b_result0", result_o, 32'h0000_000C);
    chk("b2b_ready0", 32'(ready_o), 32'd1);
    operator_i = 4'(ALU_SUB); operand_a_i = 32'h10; operand_b_i = 32'd3;
    @(negedge clk);
    $display("op b2b      ADD then SUB -> result=%h", result_o);
    chk("b2b_valid1", 32'(valid_o), 32'd1);
    chk("b2b_result1", result_o, 32'h0000_000D);
    valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(valid_o), 32'd0);

    // Output stall: result held, new requests refused
    ready_i = 1'b0;
    operator_i = 4'(ALU_XOR); operand_a_i = 32'hA5A5_A5A5; operand_b_i = 32'hFFFF_FFFF; valid_i = 1'b1;
    @(negedge clk);
    operator_i = 4'(ALU_ADD); operand_a_i = 32'd1; operand_b_i = 32'd1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_result", result_o, 32'h5A5A_5A5A);
      chk("stall_ready", 32'(ready_o), 32'd0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1;
    chk("stall_release_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    $display("op stall    XOR held, then ADD -> result=%h", result_o);
    chk("stall_next_valid", 32'(valid_o), 32'd1);
    chk("stall_next_result", result_o, 32'h0000_0002);
    valid_i = 1'b0;
    @(negedge clk);

    // Flush while idle with a request present: must not be accepted
    // (first restore SLT so result/cmp are nonzero for later checks)
    run_op("SLT2", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b1, 1);
    flush_i = 1'b1; valid_i = 1'b1; operator_i = 4'(ALU_ADD); operand_a_i = 32'd9; operand_b_i = 32'd9;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_idle_busy", 32'(busy_o), 32'd0);
    chk("flush_idle_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    chk("flush_idle_valid2", 32'(valid_o), 32'd0);

    // Flush during a long shift
    operator_i = 4'(ALU_SRL); operand_a_i = 32'hFFFF_FFFF; operand_b_i = 32'd31; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("flush_shift_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; operator_i = 4'(ALU_ADD);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    $display("op flush    SRL31 flushed -> valid=%0d ready=%0d", valid_o, ready_o);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_result_kept", result_o, 32'h0000_0001);
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid_o) seen_valid = 1'b1;
    end
    chk("flush_no_late_valid", 32'(seen_valid), 32'd0);

    // Reset during a long shift
    operator_i = 4'(ALU_SRL); operand_a_i = 32'hFFFF_FFFF; operand_b_i = 32'd31; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("op reset    SRL31 reset -> valid=%0d result=%h", valid_o, result_o);
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    chk("rst_mid_cmp", 32'(cmp_result_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_ready", 32'(ready_o), 32'd1);

    // Recovery after reset
    run_op("ADD_rec", ALU_ADD, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
